// File: rtl/alu_issue_pkg.sv
// Shared decode constants for the ALU issue unit: opcodes, alusignals bit positions,
// instruction field positions and the RUN/HALT state encoding.
package alu_issue_pkg;

    localparam int unsigned AW = 12;

    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpSub = 4'd1;
    localparam logic [3:0] OpMul = 4'd2;
    localparam logic [3:0] OpCmp = 4'd3;
    localparam logic [3:0] OpMov = 4'd4;
    localparam logic [3:0] OpOr  = 4'd5;
    localparam logic [3:0] OpAnd = 4'd6;
    localparam logic [3:0] OpNot = 4'd7;
    localparam logic [3:0] OpLsl = 4'd8;
    localparam logic [3:0] OpLsr = 4'd9;

    localparam int unsigned SigAdd = 0;
    localparam int unsigned SigSub = 3;
    localparam int unsigned SigMul = 4;
    localparam int unsigned SigCmp = 5;
    localparam int unsigned SigMov = 6;
    localparam int unsigned SigOr  = 7;
    localparam int unsigned SigAnd = 8;
    localparam int unsigned SigNot = 9;
    localparam int unsigned SigLsl = 10;
    localparam int unsigned SigLsr = 11;

    localparam int unsigned OpcLsb  = 12;
    localparam int unsigned OpcMsb  = 15;
    localparam int unsigned RdLsb   = 9;
    localparam int unsigned RdMsb   = 11;
    localparam int unsigned Rs1Lsb  = 6;
    localparam int unsigned Rs1Msb  = 8;
    localparam int unsigned ImmBit  = 5;
    localparam int unsigned Imm5Lsb = 0;
    localparam int unsigned Imm5Msb = 4;
    localparam int unsigned Rs2Lsb  = 0;
    localparam int unsigned Rs2Msb  = 2;

    typedef enum logic {
        StRun  = 1'b0,
        StHalt = 1'b1
    } state_e;

    function automatic logic [AW-1:0] alu_onehot(input logic [3:0] opc);
        logic [AW-1:0] sig;
        sig = '0;
        case (opc)
            OpAdd:   sig[SigAdd] = 1'b1;
            OpSub:   sig[SigSub] = 1'b1;
            OpMul:   sig[SigMul] = 1'b1;
            OpCmp:   sig[SigCmp] = 1'b1;
            OpMov:   sig[SigMov] = 1'b1;
            OpOr:    sig[SigOr]  = 1'b1;
            OpAnd:   sig[SigAnd] = 1'b1;
            OpNot:   sig[SigNot] = 1'b1;
            OpLsl:   sig[SigLsl] = 1'b1;
            OpLsr:   sig[SigLsr] = 1'b1;
            default: sig = '0;
        endcase
        return sig;
    endfunction

endpackage

// File: rtl/alu_scoreboard.sv
// Busy-bit scoreboard with set/clear ports and a combinational hazard check.
// ALU_ISSUE_BYPASS_EN lets a same-cycle write-back hide its busy bit from the check.
module alu_scoreboard
    import alu_issue_pkg::*;
#(
    parameter int unsigned NREG = 8,
    localparam int unsigned IW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_en,
    input  logic [IW-1:0]   set_idx,
    input  logic            clr_en,
    input  logic [IW-1:0]   clr_idx,
    input  logic [NREG-1:0] chk_mask,
    output logic            hazard,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_q, busy_d, set_mask, clr_mask, eff_busy;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_idx] = 1'b1;
        if (clr_en) clr_mask[clr_idx] = 1'b1;
        // Set is applied after clear so a colliding issue keeps the register busy.
        busy_d = (busy_q & ~clr_mask) | set_mask;
`ifdef ALU_ISSUE_BYPASS_EN
        eff_busy = busy_q & ~clr_mask;
`else
        eff_busy = busy_q;
`endif
        hazard = |(eff_busy & chk_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy = busy_q;

endmodule

// File: rtl/alu_issue_unit.sv
// Decode/issue stage for the 16-bit ALU: one-entry decode slot, 8x16 regfile, scoreboard.
// Define ALU_ISSUE_BYPASS_EN to forward write-back data into a same-cycle issue.
module alu_issue_unit
    import alu_issue_pkg::*;
#(
    parameter int unsigned NREG = 8,
    parameter int unsigned DW = 16,
    localparam int unsigned RW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     in_instr,
    input  logic            wb_valid,
    input  logic [RW-1:0]   wb_rd,
    input  logic [DW-1:0]   wb_data,
    output logic [AW-1:0]   alusignals,
    output logic [DW-1:0]   op1,
    output logic [DW-1:0]   op2,
    output logic [4:0]      immx,
    output logic            isimmediate,
    output logic            iss_valid,
    output logic [RW-1:0]   iss_rd,
    output logic            illegal,
    output logic [NREG-1:0] busy_vec
);

    state_e          state_q, state_d;
    logic            d_valid_q;
    logic [15:0]     d_instr_q;
    logic [DW-1:0]   rf_q [NREG];

    logic [3:0]      opc;
    logic [RW-1:0]   rd, rs1, rs2;
    logic            imm, is_illegal, uses_rs1, uses_rs2, writes_rd;
    logic [NREG-1:0] chk_mask;
    logic            hazard, issue_fire, accept;
    logic [DW-1:0]   rs1_val, rs2_val;

    assign opc = d_instr_q[OpcMsb:OpcLsb];
    assign rd  = d_instr_q[RdMsb:RdLsb];
    assign rs1 = d_instr_q[Rs1Msb:Rs1Lsb];
    assign rs2 = d_instr_q[Rs2Msb:Rs2Lsb];
    assign imm = d_instr_q[ImmBit];

    assign is_illegal = opc > OpLsr;
    assign uses_rs1   = ~is_illegal & (opc != OpMov);
    assign uses_rs2   = ~is_illegal & ~imm & (opc != OpNot);
    assign writes_rd  = ~is_illegal & (opc != OpCmp);

    always_comb begin
        chk_mask = '0;
        if (uses_rs1)  chk_mask[rs1] = 1'b1;
        if (uses_rs2)  chk_mask[rs2] = 1'b1;
        if (writes_rd) chk_mask[rd]  = 1'b1;
    end

    assign issue_fire = d_valid_q & ~hazard & ~is_illegal & (state_q == StRun);
    assign in_ready   = (state_q == StRun) & (~d_valid_q | issue_fire);
    assign accept     = in_valid & in_ready;

    alu_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (issue_fire & writes_rd),
        .set_idx  (rd),
        .clr_en   (wb_valid),
        .clr_idx  (wb_rd),
        .chk_mask (chk_mask),
        .hazard   (hazard),
        .busy     (busy_vec)
    );

    always_comb begin
        rs1_val = rf_q[rs1];
        rs2_val = rf_q[rs2];
`ifdef ALU_ISSUE_BYPASS_EN
        if (wb_valid && wb_rd == rs1) rs1_val = wb_data;
        if (wb_valid && wb_rd == rs2) rs2_val = wb_data;
`endif
    end

    always_comb begin
        state_d = state_q;
        if (state_q == StRun && d_valid_q && is_illegal) state_d = StHalt;
    end

    assign illegal = (state_q == StHalt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            d_valid_q <= 1'b0;
            d_instr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                d_valid_q <= 1'b1;
                d_instr_q <= in_instr;
            end else if (issue_fire) begin
                d_valid_q <= 1'b0;
            end
        end
    end

    // Write-backs keep landing in HALT so the result stage can drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
        end else if (wb_valid) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid   <= 1'b0;
            alusignals  <= '0;
            iss_rd      <= '0;
            op1         <= '0;
            op2         <= '0;
            immx        <= '0;
            isimmediate <= 1'b0;
        end else begin
            iss_valid  <= issue_fire;
            alusignals <= issue_fire ? alu_onehot(opc) : '0;
            if (issue_fire) begin
                iss_rd      <= rd;
                op1         <= rs1_val;
                op2         <= imm ? '0 : rs2_val;
                immx        <= d_instr_q[Imm5Msb:Imm5Lsb];
                isimmediate <= imm;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed self-checking bench for alu_issue_unit; expected values are hand-computed
// from the instruction encoding. Latency expectations follow ALU_ISSUE_BYPASS_EN.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [11:0] alusignals;
    logic [15:0] op1, op2;
    logic [4:0]  immx;
    logic        isimmediate;
    logic        iss_valid;
    logic [2:0]  iss_rd;
    logic        illegal;
    logic [7:0]  busy_vec;

    int n_vec = 0;
    int n_err = 0;

    alu_issue_unit u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .alusignals  (alusignals),
        .op1         (op1),
        .op2         (op2),
        .immx        (immx),
        .isimmediate (isimmediate),
        .iss_valid   (iss_valid),
        .iss_rd      (iss_rd),
        .illegal     (illegal),
        .busy_vec    (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [2:0] rd, input logic [15:0] data);
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = data;
        tick();
        wb_valid = 1'b0;
    endtask

    // Present an instruction and return just after the edge that accepts it.
    task automatic offer(input logic [15:0] instr);
        in_valid = 1'b1;
        in_instr = instr;
        for (int k = 0; k < 20 && !in_ready; k++) tick();
        check("accept_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        wb_valid = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_iss_valid", 32'(iss_valid), 32'd0);
        check("rst_alusignals", 32'(alusignals), 32'h0);
        check("rst_op1", 32'(op1), 32'h0);
        check("rst_busy", 32'(busy_vec), 32'h0);
        check("rst_illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // add r3,r1,r2 after r1=5, r2=3
        wb(3'd1, 16'd5);
        wb(3'd2, 16'd3);
        offer(16'h0642);
        tick();
        check("add_iss_valid", 32'(iss_valid), 32'd1);
        check("add_alusignals", 32'(alusignals), 32'h001);
        check("add_op1", 32'(op1), 32'd5);
        check("add_op2", 32'(op2), 32'd3);
        check("add_iss_rd", 32'(iss_rd), 32'd3);
        check("add_busy", 32'(busy_vec), 32'h08);
        tick();
        check("idle_iss_valid", 32'(iss_valid), 32'd0);
        check("idle_alusignals", 32'(alusignals), 32'h0);
        check("idle_op1_hold", 32'(op1), 32'd5);

        // mov r4,#3
        offer(16'h4823);
        tick();
        check("mov_alusignals", 32'(alusignals), 32'h040);
        check("mov_isimm", 32'(isimmediate), 32'd1);
        check("mov_immx", 32'(immx), 32'd3);
        check("mov_op2", 32'(op2), 32'd0);
        check("mov_busy", 32'(busy_vec), 32'h18);
        wb(3'd3, 16'd8);
        wb(3'd4, 16'd3);
        check("drain_busy", 32'(busy_vec), 32'h0);

        // sub r5,r1,r2 then dependent add r6,r5,r1
        offer(16'h1A42);
        offer(16'h0D41);
        check("sub_iss_valid", 32'(iss_valid), 32'd1);
        check("sub_alusignals", 32'(alusignals), 32'h008);
        check("sub_busy", 32'(busy_vec), 32'h20);
        check("raw_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("raw_stall_iss", 32'(iss_valid), 32'd0);
        check("raw_stall_ready", 32'(in_ready), 32'd0);
        wb(3'd5, 16'd2);
`ifdef ALU_ISSUE_BYPASS_EN
        check("raw_iss_on_wb", 32'(iss_valid), 32'd1);
`else
        check("raw_no_iss_on_wb", 32'(iss_valid), 32'd0);
        tick();
        check("raw_iss_after_wb", 32'(iss_valid), 32'd1);
`endif
        check("raw_alusignals", 32'(alusignals), 32'h001);
        check("raw_op1", 32'(op1), 32'd2);
        check("raw_op2", 32'(op2), 32'd5);
        check("raw_iss_rd", 32'(iss_rd), 32'd6);
        check("raw_busy", 32'(busy_vec), 32'h40);
        wb(3'd6, 16'd7);

        // cmp r1,r2 then mov r1,#7 back to back
        offer(16'h3042);
        offer(16'h4227);
        check("cmp_iss_valid", 32'(iss_valid), 32'd1);
        check("cmp_alusignals", 32'(alusignals), 32'h020);
        check("cmp_busy", 32'(busy_vec), 32'h00);
        tick();
        check("cmp_next_iss", 32'(iss_valid), 32'd1);
        check("cmp_next_sig", 32'(alusignals), 32'h040);
        check("cmp_next_rd", 32'(iss_rd), 32'd1);
        check("cmp_next_immx", 32'(immx), 32'd7);
        check("cmp_next_busy", 32'(busy_vec), 32'h02);
        wb(3'd1, 16'd5);

        // async reset during a RAW stall
        offer(16'h1A42);
        offer(16'h0D41);
        tick();
        check("ar_stalled", 32'(in_ready), 32'd0);
        #3 rst_n = 1'b0;
        #1;
        check("ar_iss_valid", 32'(iss_valid), 32'd0);
        check("ar_alusignals", 32'(alusignals), 32'h0);
        check("ar_op1", 32'(op1), 32'h0);
        check("ar_busy", 32'(busy_vec), 32'h0);
        #2 rst_n = 1'b1;
        tick();
        tick();
        check("ar_dropped", 32'(iss_valid), 32'd0);
        check("ar_ready", 32'(in_ready), 32'd1);
        check("ar_busy_after", 32'(busy_vec), 32'h0);

        // illegal opcode halts until reset
        offer(16'hA000);
        check("ill_ready_held", 32'(in_ready), 32'd0);
        tick();
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_ready", 32'(in_ready), 32'd0);
        check("ill_no_iss", 32'(iss_valid), 32'd0);
        in_valid = 1'b1;
        in_instr = 16'h0642;
        repeat (3) tick();
        check("halt_ready", 32'(in_ready), 32'd0);
        check("halt_no_iss", 32'(iss_valid), 32'd0);
        check("halt_flag", 32'(illegal), 32'd1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        check("unhalt_flag", 32'(illegal), 32'd0);
        check("unhalt_ready", 32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
